// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 registers the offered operands; S2 computes and registers result + flags.
// Optional feature macro: ALU_SHIFT_EN (enables SHL/SHR/SRA, opcodes 8-10);
// when undefined those opcodes are treated as illegal and no shifter exists.
module alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       oper,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_RSUB = 4'd2,
    OP_OR   = 4'd3,
    OP_AND  = 4'd4,
    OP_XOR  = 4'd5,
    OP_XNOR = 4'd6,
    OP_ADDC = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_SRA  = 4'd10
  } op_e;

  // Stage 1 holding registers
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [3:0]       s1_op_q;

  // Stage 2 registers (drive the outputs directly)
  logic             s2_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             c_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;
  logic             err_q;
  logic             carry_q;

  // Next-state values computed from S1
  logic [WIDTH-1:0] result_d;
  logic             c_d;
  logic             zero_d;
  logic             neg_d;
  logic             ovf_d;
  logic             err_d;
  logic             carry_d;
  logic [WIDTH:0]   sum;
  logic             cin;

  logic xfer;
  logic accept;

`ifdef ALU_SHIFT_EN
  localparam int unsigned SHW = $clog2(WIDTH);
  logic [SHW-1:0] sh;
  assign sh = s1_b_q[SHW-1:0];
`endif

  assign xfer     = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !res && (!s1_valid_q || xfer);
  assign accept   = in_valid && in_ready;

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign c_out     = c_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

  // Operation decode and flag generation for the op sitting in S1
  always_comb begin
    result_d = '0;
    c_d      = 1'b0;
    ovf_d    = 1'b0;
    err_d    = 1'b0;
    carry_d  = carry_q;
    sum      = '0;
    cin      = 1'b0;
    case (s1_op_q)
      OP_ADD, OP_ADDC: begin
        cin      = (s1_op_q == OP_ADDC) && carry_q;
        sum      = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, cin};
        result_d = sum[WIDTH-1:0];
        c_d      = sum[WIDTH];
        ovf_d    = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                   (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
        carry_d  = sum[WIDTH];
      end
      OP_SUB: begin
        sum      = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        result_d = sum[WIDTH-1:0];
        c_d      = sum[WIDTH];
        ovf_d    = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                   (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
        carry_d  = sum[WIDTH];
      end
      OP_RSUB: begin
        sum      = {1'b0, s1_b_q} - {1'b0, s1_a_q};
        result_d = sum[WIDTH-1:0];
        c_d      = sum[WIDTH];
        ovf_d    = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                   (sum[WIDTH-1] != s1_b_q[WIDTH-1]);
        carry_d  = sum[WIDTH];
      end
      OP_OR:   result_d = s1_a_q | s1_b_q;
      OP_AND:  result_d = s1_a_q & s1_b_q;
      OP_XOR:  result_d = s1_a_q ^ s1_b_q;
      OP_XNOR: result_d = ~(s1_a_q ^ s1_b_q);
`ifdef ALU_SHIFT_EN
      OP_SHL:  result_d = s1_a_q << sh;
      OP_SHR:  result_d = s1_a_q >> sh;
      OP_SRA:  result_d = $signed(s1_a_q) >>> sh;
`endif
      default: err_d = 1'b1;
    endcase
    zero_d = (result_d == '0);
    neg_d  = result_d[WIDTH-1];
  end

  // Stage 1: capture operands on accept, empty when the op moves to S2
  always_ff @(posedge clk) begin
    if (res) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= a;
      s1_b_q     <= b;
      s1_op_q    <= oper;
    end else if (xfer) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2: register result/flags on transfer, hold while the sink stalls
  always_ff @(posedge clk) begin
    if (res) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      c_q        <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      carry_q    <= 1'b0;
    end else if (xfer) begin
      s2_valid_q <= 1'b1;
      result_q   <= result_d;
      c_q        <= c_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      carry_q    <= carry_d;
    end else if (out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH = 8).
// A queue-based reference model predicts every delivered result in order;
// directed sequences pin known literal values. Honours ALU_SHIFT_EN.
module tb_alu_pipe;
  localparam int W    = 8;
  localparam int VW   = W + 5;
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);
  localparam int SMAX = HALF - 1;
  localparam int SMIN = -HALF;

  logic         clk = 1'b0;
  logic         res = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   oper = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         c_out, zero, neg, ovf, err;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .oper(oper), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .c_out(c_out), .zero(zero), .neg(neg), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] v;
    int            stamp;
  } ent_t;

  ent_t          mq[$];
  logic [VW-1:0] got[$];
  int            mcarry = 0;
  int            cyc = 0;
  bit            chk_en = 1'b0;
  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] lit(input logic [W-1:0] r, input bit c, input bit z,
                                        input bit n, input bit o, input bit e);
    return {r, c, z, n, o, e};
  endfunction

  // Behavioural reference: integer arithmetic, signed range check for overflow
  function automatic logic [VW-1:0] model(input int op, input int x, input int y,
                                          input int cin, output int nc);
    int r, s, sx, sy, sh;
    bit c, o, e;
    logic [W-1:0] rv;
    sx = (x >= HALF) ? x - FULL : x;
    sy = (y >= HALF) ? y - FULL : y;
    r = 0; s = 0; c = 0; o = 0; e = 0; nc = cin; sh = y % W;
    case (op)
      0:  begin r = x + y;       s = sx + sy;       c = (r >= FULL); o = (s > SMAX || s < SMIN); nc = int'(c); end
      7:  begin r = x + y + cin; s = sx + sy + cin; c = (r >= FULL); o = (s > SMAX || s < SMIN); nc = int'(c); end
      1:  begin r = x - y;       s = sx - sy;       c = (x < y);     o = (s > SMAX || s < SMIN); nc = int'(c); end
      2:  begin r = y - x;       s = sy - sx;       c = (y < x);     o = (s > SMAX || s < SMIN); nc = int'(c); end
      3:  r = x | y;
      4:  r = x & y;
      5:  r = x ^ y;
      6:  r = ~(x ^ y);
`ifdef ALU_SHIFT_EN
      8:  r = x << sh;
      9:  r = x >> sh;
      10: r = sx >>> sh;
`endif
      default: e = 1;
    endcase
    rv = W'(r);
    return {rv, c, (rv == '0), rv[W-1], o, e};
  endfunction

  // Per-cycle compare against the model; also tracks accepts and deliveries
  always @(negedge clk) begin
    if (chk_en) begin
      int nc;
      logic [VW-1:0] ev;
      check("in_ready", {31'b0, in_ready}, {31'b0, (!res && (mq.size() < 2 || out_ready))});
      check("out_valid", {31'b0, out_valid},
            {31'b0, (mq.size() > 0 && (cyc - mq[0].stamp) >= 1)});
      if (out_valid && mq.size() > 0)
        check("outputs", {19'b0, result, c_out, zero, neg, ovf, err}, {19'b0, mq[0].v});
      if (res) begin
        mq.delete();
        mcarry = 0;
      end else begin
        if (out_valid && out_ready && mq.size() > 0) begin
          got.push_back({result, c_out, zero, neg, ovf, err});
          void'(mq.pop_front());
        end
        if (in_valid && in_ready) begin
          ev = model(int'(oper), int'(a), int'(b), mcarry, nc);
          mcarry = nc;
          mq.push_back('{v: ev, stamp: cyc + 1});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    bit ok;
    int n;
    in_valid = 1'b1; oper = op; a = x; b = y;
    n = 0; ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: op 0x%0h not accepted in %0d cycles", op, n);
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_got(input string nm, input int idx, input logic [VW-1:0] exp);
    if (idx >= got.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: result missing (have %0d) expected 0x%0h", nm, got.size(), exp);
    end else
      check(nm, {19'b0, got[idx]}, {19'b0, exp});
  endtask

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return W'(SMAX);
      3: return W'(HALF);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit held;
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_flags", {19'b0, result, c_out, zero, neg, ovf, err}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    res = 1'b0;
    chk_en = 1'b1;

    // ADD then back-to-back ADDCs chaining the carry
    base = got.size();
    send(4'd0, 8'hFF, 8'hA1);
    send(4'd7, 8'h00, 8'h00);
    send(4'd7, 8'h00, 8'h00);
    idle(4);
    chk_got("add_ff_a1", base,     lit(8'hA0, 1, 0, 1, 0, 0));
    chk_got("addc_c1",   base + 1, lit(8'h01, 0, 0, 0, 0, 0));
    chk_got("addc_c0",   base + 2, lit(8'h00, 0, 1, 0, 0, 0));

    base = got.size();
    send(4'd1, 8'h04, 8'h09);
    send(4'd0, 8'h7F, 8'h01);
    send(4'd2, 8'h04, 8'h09);
    idle(4);
    chk_got("sub_4_9",  base,     lit(8'hFB, 1, 0, 1, 0, 0));
    chk_got("add_ovf",  base + 1, lit(8'h80, 0, 0, 1, 1, 0));
    chk_got("rsub_4_9", base + 2, lit(8'h05, 0, 0, 0, 0, 0));

    // Backpressure: two ops held, third refused until the sink drains
    out_ready = 1'b0;
    base = got.size();
    send(4'd6, 8'h06, 8'h61);
    send(4'd4, 8'h60, 8'h21);
    in_valid = 1'b1; oper = 4'd3; a = 8'h03; b = 8'h05;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_hold", {24'b0, result}, 32'h98);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(4'd3, 8'h03, 8'h05);
    idle(5);
    chk_got("bp_xnor", base,     lit(8'h98, 0, 0, 1, 0, 0));
    chk_got("bp_and",  base + 1, lit(8'h20, 0, 0, 0, 0, 0));
    chk_got("bp_or",   base + 2, lit(8'h07, 0, 0, 0, 0, 0));

    // Shift ops and illegal opcode
    base = got.size();
    send(4'd8, 8'h03, 8'h02);
    send(4'd10, 8'h80, 8'h01);
    send(4'd15, 8'h12, 8'h34);
    idle(4);
`ifdef ALU_SHIFT_EN
    chk_got("shl", base,     lit(8'h0C, 0, 0, 0, 0, 0));
    chk_got("sra", base + 1, lit(8'hC0, 0, 0, 1, 0, 0));
`else
    chk_got("shl_off", base,     lit(8'h00, 0, 1, 0, 0, 1));
    chk_got("sra_off", base + 1, lit(8'h00, 0, 1, 0, 0, 1));
`endif
    chk_got("illegal", base + 2, lit(8'h00, 0, 1, 0, 0, 1));

    // Reset with two ops in flight and carry set
    base = got.size();
    send(4'd0, 8'hFF, 8'h01);
    idle(3);
    chk_got("carry_set", base, lit(8'h00, 1, 1, 0, 0, 0));
    out_ready = 1'b0;
    send(4'd0, 8'h01, 8'h01);
    send(4'd0, 8'h02, 8'h02);
    base = got.size();
    res = 1'b1;
    @(posedge clk);
    #1;
    res = 1'b0;
    check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    send(4'd7, 8'h01, 8'h01);
    idle(4);
    check("rst_no_stale", got.size(), base + 1);
    chk_got("addc_after_rst", base, lit(8'h02, 0, 0, 0, 0, 0));

    // Randomised traffic with random sink backpressure
    held = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!held) begin
        in_valid = ($urandom_range(0, 9) < 7);
        oper     = 4'($urandom_range(0, 15));
        a        = rnd();
        b        = rnd();
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      held = in_valid && !in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(5);
    check("drained", mq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
